// File: rtl/corelet_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : corelet_ctrl_if
//  Purpose  : Bundles the tile-control request/config inputs, the corelet
//             status flags and the sequencer outputs of corelet_ctrl.
//  Ports    : master - host/corelet side (drives start, config, status flags)
//             slave  - sequencer side (drives inst, busy, done)
//  Revision : 1.0 - initial release
// ============================================================================
interface corelet_ctrl_if #(
  parameter int ADDR_BW = 11
);
  logic               start;
  logic               mode;
  logic [ADDR_BW-1:0] w_base;
  logic [ADDR_BW-1:0] a_base;
  logic [ADDR_BW-1:0] p_base;
  logic [ADDR_BW-1:0] n_act;
  logic               ofifo_valid;
  logic               l0_full;
  logic [34:0]        inst;
  logic               busy;
  logic               done;

  modport master (
    output start, mode, w_base, a_base, p_base, n_act, ofifo_valid, l0_full,
    input  inst, busy, done
  );

  modport slave (
    input  start, mode, w_base, a_base, p_base, n_act, ofifo_valid, l0_full,
    output inst, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/corelet_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : corelet_ctrl
//  Purpose  : Tile instruction sequencer for one corelet plus its xmem/pmem
//             SRAMs: kernel fill/load, kernel settle, activation fill/execute
//             and OFIFO drain into pmem, emitted as a registered 35-bit word.
//  Ports    : clk   - clock
//             reset - asynchronous active-low reset
//             bus   - corelet_ctrl_if.slave (start/config/status in,
//                     inst/busy/done out)
//  Revision : 1.0 - initial release
// ============================================================================
module corelet_ctrl #(
  parameter int ROW     = 8,
  parameter int COL     = 8,
  parameter int ADDR_BW = 11
) (
  input wire            clk,
  input wire            reset,
  corelet_ctrl_if.slave bus
);

  localparam int CNT_W = ADDR_BW + 1;

  // instruction word bit map
  localparam int B_MODE     = 34;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_A_PMEM   = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_A_XMEM   = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_RD = 5;
  localparam int B_IFIFO_WR = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  localparam logic [34:0] C_NOP = (35'd1 << B_CEN_P) | (35'd1 << B_WEN_P) |
                                  (35'd1 << B_CEN_X) | (35'd1 << B_WEN_X);

  localparam logic [CNT_W-1:0] C_COL_CNT  = CNT_W'(COL);
  localparam logic [CNT_W-1:0] C_WAIT_CNT = CNT_W'(ROW + COL);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_W_FILL = 3'd1,
    S_W_LOAD = 3'd2,
    S_W_WAIT = 3'd3,
    S_A_FILL = 3'd4,
    S_A_EXEC = 3'd5,
    S_DRAIN  = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  // state_q names the phase of the word currently held in inst_q;
  // cnt_q counts items issued so far in that phase (reads, loads, wait cycles)
  // and pend_q flags an issued read whose delayed write has not gone out yet.
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               mode_q, mode_d;
  logic [ADDR_BW-1:0] w_base_q, w_base_d;
  logic [ADDR_BW-1:0] a_base_q, a_base_d;
  logic [ADDR_BW-1:0] p_base_q, p_base_d;
  logic [ADDR_BW-1:0] n_act_q, n_act_d;
  logic [34:0]        inst_q, inst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   cnt_base;
  logic               pend_base;
  logic [CNT_W-1:0]   n_cnt;
  logic [CNT_W-1:0]   fill_len;
  logic [ADDR_BW-1:0] fill_base;
  logic [CNT_W-1:0]   wr_idx;
  logic               kern_fill;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      mode_q   <= 1'b0;
      w_base_q <= '0;
      a_base_q <= '0;
      p_base_q <= '0;
      n_act_q  <= '0;
      inst_q   <= C_NOP;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      mode_q   <= mode_d;
      w_base_q <= w_base_d;
      a_base_q <= a_base_d;
      p_base_q <= p_base_d;
      n_act_q  <= n_act_d;
      inst_q   <= inst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    // Config: the launching word must already use the live start values.
    mode_d   = mode_q;
    w_base_d = w_base_q;
    a_base_d = a_base_q;
    p_base_d = p_base_q;
    n_act_d  = n_act_q;
    if (state_q == S_IDLE && bus.start) begin
      mode_d   = bus.mode;
      w_base_d = bus.w_base;
      a_base_d = bus.a_base;
      p_base_d = bus.p_base;
      n_act_d  = bus.n_act;
    end
    n_cnt = CNT_W'(n_act_d);

    // Phase of the next word, decided from what the current word completed.
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_W_FILL;
      S_W_FILL: if (cnt_q == C_COL_CNT && !pend_q) state_d = S_W_LOAD;
      S_W_LOAD: if (cnt_q == C_COL_CNT) state_d = S_W_WAIT;
      S_W_WAIT: if (cnt_q == C_WAIT_CNT) state_d = (n_act_q == '0) ? S_DONE : S_A_FILL;
      S_A_FILL: if (cnt_q == n_cnt && !pend_q) state_d = S_A_EXEC;
      S_A_EXEC: if (cnt_q == n_cnt) state_d = S_DRAIN;
      S_DRAIN:  if (cnt_q == n_cnt && !pend_q) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Counters restart whenever the next word opens a new phase.
    if (state_d != state_q) begin
      cnt_base  = '0;
      pend_base = 1'b0;
    end else begin
      cnt_base  = cnt_q;
      pend_base = pend_q;
    end

    inst_d    = C_NOP;
    cnt_d     = cnt_base;
    pend_d    = pend_base;
    done_d    = 1'b0;
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
    kern_fill = (state_d == S_W_FILL);
    fill_len  = kern_fill ? C_COL_CNT : n_cnt;
    fill_base = kern_fill ? w_base_d : a_base_d;
    wr_idx    = cnt_base - CNT_W'(pend_base);

    if (busy_d) inst_d[B_MODE] = mode_d;

    case (state_d)
      S_W_FILL, S_A_FILL: begin
        if (bus.l0_full) begin
          // Stall: neither read nor write; xmem address parks where it was.
          inst_d[B_A_XMEM +: ADDR_BW] = inst_q[B_A_XMEM +: ADDR_BW];
        end else begin
          // Data of the previous read lands one cycle later (SRAM latency).
          if (kern_fill && mode_d) inst_d[B_IFIFO_WR] = pend_base;
          else                     inst_d[B_L0_WR]    = pend_base;
          if (cnt_base < fill_len) begin
            inst_d[B_CEN_X]             = 1'b0;
            inst_d[B_A_XMEM +: ADDR_BW] = fill_base + cnt_base[ADDR_BW-1:0];
            cnt_d                       = cnt_base + CNT_W'(1);
            pend_d                      = 1'b1;
          end else begin
            inst_d[B_A_XMEM +: ADDR_BW] = inst_q[B_A_XMEM +: ADDR_BW];
            pend_d                      = 1'b0;
          end
        end
      end
      S_W_LOAD: begin
        if (mode_d) inst_d[B_IFIFO_RD] = 1'b1;
        else        inst_d[B_L0_RD]    = 1'b1;
        inst_d[B_LOAD] = 1'b1;
        cnt_d          = cnt_base + CNT_W'(1);
      end
      S_W_WAIT: begin
        cnt_d = cnt_base + CNT_W'(1);
      end
      S_A_EXEC: begin
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_EXEC]  = 1'b1;
        cnt_d           = cnt_base + CNT_W'(1);
      end
      S_DRAIN: begin
        // pmem write trails each OFIFO read by one cycle; index = writes so far.
        if (pend_base) begin
          inst_d[B_CEN_P]             = 1'b0;
          inst_d[B_WEN_P]             = 1'b0;
          inst_d[B_A_PMEM +: ADDR_BW] = p_base_d + wr_idx[ADDR_BW-1:0];
        end
        if (bus.ofifo_valid && cnt_base < n_cnt) begin
          inst_d[B_OFIFO_RD] = 1'b1;
          cnt_d              = cnt_base + CNT_W'(1);
          pend_d             = 1'b1;
        end else begin
          pend_d = 1'b0;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        cnt_d  = '0;
        pend_d = 1'b0;
      end
    endcase
  end

  assign bus.inst = inst_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_corelet_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_corelet_ctrl
//  Purpose  : Self-checking bench for corelet_ctrl. Logs every emitted
//             instruction word as transactions (xmem reads, buffer writes,
//             loads, executes, OFIFO reads, pmem writes) and compares them
//             with the tile rules computed from the tile configuration.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_corelet_ctrl;

  localparam int ROW  = 8;
  localparam int COL  = 8;
  localparam int AW   = 11;
  localparam int AMOD = 1 << AW;

  logic clk;
  logic reset;

  corelet_ctrl_if #(.ADDR_BW(AW)) bus ();

  corelet_ctrl #(.ROW(ROW), .COL(COL), .ADDR_BW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  longint nop_word;

  // ---------------- monitor state ----------------
  bit   mon_on = 1'b0;
  int   cyc;
  bit   exp_mode;
  bit   stall_en;
  int   valid_pct;
  int   busy_start_at;
  logic [34:0] mon_w;

  int rd_cyc[$], rd_addr[$], wr_cyc[$], load_cyc[$], exec_cyc[$];
  int ofrd_cyc[$], pw_cyc[$], pw_addr[$], full_hist[$], valid_hist[$];
  int n_l0wr, n_ifwr, n_l0rd, n_ifrd, n_load_rd, n_exec_rd;
  int n_done, done_cyc, busy_bad, mode_bad, acc_bad, stall_bad;

  always @(negedge clk) begin
    if (mon_on) begin
      mon_w = bus.inst;
      if (!mon_w[19]) begin
        rd_cyc.push_back(cyc);
        rd_addr.push_back(int'(mon_w[17:7]));
      end
      if (mon_w[2] || mon_w[4]) wr_cyc.push_back(cyc);
      if ((!mon_w[19] || mon_w[2] || mon_w[4]) && full_hist[cyc] != 0) stall_bad++;
      n_l0wr += int'(mon_w[2]);
      n_ifwr += int'(mon_w[4]);
      n_l0rd += int'(mon_w[3]);
      n_ifrd += int'(mon_w[5]);
      if (mon_w[0]) begin
        load_cyc.push_back(cyc);
        if (exp_mode ? mon_w[5] : mon_w[3]) n_load_rd++;
      end
      if (mon_w[1]) begin
        exec_cyc.push_back(cyc);
        if (mon_w[3]) n_exec_rd++;
      end
      if (mon_w[6]) ofrd_cyc.push_back(cyc);
      if (!mon_w[32] && !mon_w[31]) begin
        pw_cyc.push_back(cyc);
        pw_addr.push_back(int'(mon_w[30:20]));
      end
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
        if (bus.busy) busy_bad++;
      end else if (n_done == 0 && !bus.busy) begin
        busy_bad++;
      end
      if (n_done == 0 && bus.busy && mon_w[34] != exp_mode) mode_bad++;
      if (mon_w[33]) acc_bad++;
      full_hist.push_back(int'(bus.l0_full));
      valid_hist.push_back(int'(bus.ofifo_valid));
      cyc++;
    end
  end

  // ---------------- per-cycle random stimulus during a tile ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mon_on) begin
        bus.l0_full     = stall_en && ($urandom_range(0, 3) == 0);
        bus.ofifo_valid = (valid_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < valid_pct);
        bus.start       = (cyc == busy_start_at);
        // config inputs wander after launch; the tile must use latched values
        bus.mode        = 1'($urandom_range(0, 1));
        bus.w_base      = AW'($urandom_range(0, AMOD - 1));
        bus.a_base      = AW'($urandom_range(0, AMOD - 1));
        bus.p_base      = AW'($urandom_range(0, AMOD - 1));
        bus.n_act       = AW'($urandom_range(0, AMOD - 1));
      end
    end
  end

  task automatic clear_logs();
    rd_cyc.delete(); rd_addr.delete(); wr_cyc.delete(); load_cyc.delete();
    exec_cyc.delete(); ofrd_cyc.delete(); pw_cyc.delete(); pw_addr.delete();
    full_hist.delete(); valid_hist.delete();
    full_hist.push_back(0);  // l0_full seen at the launching edge
    valid_hist.push_back(0);
    n_l0wr = 0; n_ifwr = 0; n_l0rd = 0; n_ifrd = 0; n_load_rd = 0; n_exec_rd = 0;
    n_done = 0; done_cyc = -1; busy_bad = 0; mode_bad = 0; acc_bad = 0; stall_bad = 0;
  endtask

  task automatic launch(input bit m, input int wb, input int ab, input int pb, input int n,
                        input bit stl, input int vp);
    @(posedge clk);
    #1;
    bus.mode   = m;
    bus.w_base = AW'(wb);
    bus.a_base = AW'(ab);
    bus.p_base = AW'(pb);
    bus.n_act  = AW'(n);
    bus.start  = 1'b1;
    bus.l0_full = 1'b0;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    exp_mode      = m;
    stall_en      = stl;
    valid_pct     = vp;
    busy_start_at = 3;
    clear_logs();
    cyc    = 0;
    mon_on = 1'b1;
  endtask

  task automatic verify_tile(input bit m, input int wb, input int ab, input int pb, input int n,
                             input bit stl, input int vp);
    int bad;
    int last_ld;
    int drain_lo;
    bit is_rd[int];
    check_eq("done_pulses", n_done, 1);
    check_eq("busy_window", busy_bad, 0);
    check_eq("mode_bit", mode_bad, 0);
    check_eq("acc_bit", acc_bad, 0);
    check_eq("stall_blocks_xfer", stall_bad, 0);
    check_eq("xmem_reads", rd_cyc.size(), COL + n);
    check_eq("buf_writes", wr_cyc.size(), COL + n);
    if (rd_cyc.size() == COL + n && wr_cyc.size() == COL + n) begin
      bad = 0;
      for (int i = 0; i < COL + n; i++) begin
        if (rd_addr[i] != ((i < COL) ? (wb + i) % AMOD : (ab + i - COL) % AMOD)) bad++;
        if (wr_cyc[i] <= rd_cyc[i]) bad++;
        if (i + 1 < COL + n && wr_cyc[i] > rd_cyc[i + 1]) bad++;
        if (!stl && wr_cyc[i] != rd_cyc[i] + 1) bad++;
      end
      check_eq("xmem_addr_and_write_order", bad, 0);
      if (!stl) check_eq("first_read_cycle", rd_cyc[0], 0);
    end
    check_eq("l0_wr_count", n_l0wr, (m ? 0 : COL) + n);
    check_eq("ififo_wr_count", n_ifwr, m ? COL : 0);
    check_eq("l0_rd_count", n_l0rd, (m ? 0 : COL) + n);
    check_eq("ififo_rd_count", n_ifrd, m ? COL : 0);
    check_eq("load_count", load_cyc.size(), COL);
    check_eq("load_with_rd", n_load_rd, COL);
    check_eq("exec_count", exec_cyc.size(), n);
    check_eq("exec_with_l0_rd", n_exec_rd, n);
    check_eq("ofifo_rd_count", ofrd_cyc.size(), n);
    check_eq("pmem_writes", pw_cyc.size(), n);
    if (load_cyc.size() != COL || wr_cyc.size() != COL + n) return;
    last_ld = load_cyc[COL - 1];
    check_eq("load_after_kernel_fill", load_cyc[0], wr_cyc[COL - 1] + 1);
    check_eq("load_contiguous", last_ld - load_cyc[0], COL - 1);
    if (n == 0) begin
      check_eq("done_after_wait", done_cyc, last_ld + ROW + COL + 1);
    end else begin
      if (!stl) check_eq("act_fill_after_wait", rd_cyc[COL], last_ld + ROW + COL + 1);
      else      check_eq("act_fill_not_early", int'(rd_cyc[COL] > last_ld + ROW + COL), 1);
      if (exec_cyc.size() == n && ofrd_cyc.size() == n && pw_cyc.size() == n) begin
        check_eq("exec_after_act_fill", exec_cyc[0], wr_cyc[COL + n - 1] + 1);
        check_eq("exec_contiguous", exec_cyc[n - 1] - exec_cyc[0], n - 1);
        drain_lo = exec_cyc[n - 1] + 1;
        check_eq("drain_not_early", int'(ofrd_cyc[0] >= drain_lo), 1);
        foreach (ofrd_cyc[i]) is_rd[ofrd_cyc[i]] = 1'b1;
        bad = 0;
        for (int c = drain_lo; c <= ofrd_cyc[n - 1]; c++)
          if (int'(is_rd.exists(c)) != valid_hist[c]) bad++;
        check_eq("drain_follows_valid", bad, 0);
        bad = 0;
        for (int k = 0; k < n; k++) begin
          if (pw_addr[k] != (pb + k) % AMOD) bad++;
          if (pw_cyc[k] != ofrd_cyc[k] + 1) bad++;
        end
        check_eq("pmem_addr_and_timing", bad, 0);
        check_eq("done_after_drain", done_cyc, pw_cyc[n - 1] + 1);
      end
    end
    if (!stl && vp >= 100)
      check_eq("tile_length", done_cyc, (COL + 1) + COL + (ROW + COL) + ((n > 0) ? 3 * n + 2 : 0));
  endtask

  task automatic run_tile(input bit m, input int wb, input int ab, input int pb, input int n,
                          input bit stl, input int vp, input bit start_in_done);
    launch(m, wb, ab, pb, n, stl, vp);
    while (n_done == 0 && cyc < 3000) begin
      @(negedge clk);
      #1;
    end
    if (n_done == 0) begin
      check_eq("done_timeout", 0, 1);
    end else if (start_in_done) begin
      // start presented while the DONE word is on the bus must be ignored
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      #1;
      check_eq("start_in_done_busy", longint'(bus.busy), 0);
      check_eq("start_in_done_inst", longint'(bus.inst), nop_word);
    end
    mon_on = 1'b0;
    bus.l0_full = 1'b0;
    bus.ofifo_valid = 1'b0;
    verify_tile(m, wb, ab, pb, n, stl, vp);
  endtask

  task automatic reset_mid_exec();
    launch(1'b0, 100, 200, 300, 10, 1'b0, 100);
    while (exec_cyc.size() < 3 && cyc < 500) begin
      @(negedge clk);
      #1;
    end
    check_eq("reached_exec", int'(exec_cyc.size() >= 3), 1);
    reset = 1'b0;
    #1;
    check_eq("abort_inst", longint'(bus.inst), nop_word);
    check_eq("abort_busy", longint'(bus.busy), 0);
    check_eq("abort_done", longint'(bus.done), 0);
    mon_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("abort_inst_held", longint'(bus.inst), nop_word);
    reset = 1'b1;
    bus.l0_full = 1'b0;
    bus.ofifo_valid = 1'b0;
  endtask

  initial begin
    nop_word = (64'd1 << 32) | (64'd1 << 31) | (64'd1 << 19) | (64'd1 << 18);
    reset = 1'b0;
    bus.start = 1'b0; bus.mode = 1'b0; bus.w_base = '0; bus.a_base = '0;
    bus.p_base = '0; bus.n_act = '0; bus.ofifo_valid = 1'b0; bus.l0_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_inst", longint'(bus.inst), nop_word);
    check_eq("reset_busy", longint'(bus.busy), 0);
    check_eq("reset_done", longint'(bus.done), 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    run_tile(1'b0, 0, 16, 0, 4, 1'b0, 100, 1'b0);        // WS baseline
    run_tile(1'b1, 0, 16, 0, 4, 1'b0, 100, 1'b1);        // OS baseline
    run_tile(1'b0, 32, 64, 8, 7, 1'b1, 50, 1'b0);        // l0_full stalls + gappy OFIFO
    run_tile(1'b0, 5, 9, 11, 0, 1'b0, 100, 1'b0);        // empty activation set
    run_tile(1'b1, AMOD - 3, AMOD - 2, AMOD - 4, 6, 1'b0, 100, 1'b0);  // address wrap
    reset_mid_exec();
    run_tile(1'b0, 1, 2, 3, 5, 1'b0, 100, 1'b0);         // full tile after abort

    for (int t = 0; t < 8; t++) begin
      run_tile(1'($urandom_range(0, 1)),
               int'($urandom_range(0, AMOD - 1)),
               int'($urandom_range(0, AMOD - 1)),
               int'($urandom_range(0, AMOD - 1)),
               int'($urandom_range(0, 20)),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) == 1) ? 100 : int'($urandom_range(40, 90)),
               1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
